// File: rtl/iaoq_sequencer.sv
// IAOQ front/back sequencer for the fetch stage: sequential advance, delayed-branch
// redirect, branch hold across stalls, nullify tracking. Optional: IAOQ_BRANCH_CNT_EN adds br_count.
module iaoq_sequencer #(
   parameter int AW          = 8,
   parameter int INC         = 4,
   parameter int RESET_FRONT = 0,
   parameter int RESET_BACK  = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          br_valid,
   input  logic [AW-1:0] br_target,
   input  logic          nullify_req,
   output logic [AW-1:0] iaoq_front,
   output logic [AW-1:0] iaoq_back,
   output logic          in_dslot,
   output logic          fetch_nullify,
   output logic          br_pending
`ifdef IAOQ_BRANCH_CNT_EN
   ,
   output logic [15:0]   br_count
`endif
);

   typedef enum logic [1:0] {S_RUN, S_PEND, S_DSLOT} state_e;

   state_e        state_q;
   logic [AW-1:0] front_q, back_q, pend_tgt_q;
   logic          in_dslot_q, fetch_nul_q, br_pending_q, nul_pend_q;
   logic          redirect_d;
   logic [AW-1:0] tgt_d, back_d;

   // A fresh branch this cycle beats a target held from an earlier stall.
   always_comb begin
      redirect_d = br_valid || (state_q == S_PEND);
      tgt_d      = br_valid ? br_target : pend_tgt_q;
      back_d     = redirect_d ? tgt_d : back_q + AW'(INC);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_RUN;
         front_q      <= AW'(RESET_FRONT);
         back_q       <= AW'(RESET_BACK);
         pend_tgt_q   <= '0;
         in_dslot_q   <= 1'b0;
         fetch_nul_q  <= 1'b0;
         br_pending_q <= 1'b0;
         nul_pend_q   <= 1'b0;
      end else if (!stall) begin
         front_q      <= back_q;
         back_q       <= back_d;
         in_dslot_q   <= redirect_d;
         state_q      <= redirect_d ? S_DSLOT : S_RUN;
         br_pending_q <= 1'b0;
         fetch_nul_q  <= nullify_req | nul_pend_q;
         nul_pend_q   <= 1'b0;
      end else begin
         // Frozen queue: only capture a branch or nullify to deliver on release.
         if (br_valid) begin
            pend_tgt_q   <= br_target;
            br_pending_q <= 1'b1;
            state_q      <= S_PEND;
         end
         if (nullify_req) nul_pend_q <= 1'b1;
      end
   end

`ifdef IAOQ_BRANCH_CNT_EN
   logic [15:0] br_count_q;
   always_ff @(posedge clk) begin
      if (reset)
         br_count_q <= '0;
      else if (!stall && redirect_d && br_count_q != 16'hFFFF)
         br_count_q <= br_count_q + 16'd1;
   end
   assign br_count = br_count_q;
`endif

   assign iaoq_front    = front_q;
   assign iaoq_back     = back_q;
   assign in_dslot      = in_dslot_q;
   assign fetch_nullify = fetch_nul_q;
   assign br_pending    = br_pending_q;

endmodule

// File: tb/tb_iaoq_sequencer.sv
// Random + directed bench for iaoq_sequencer against a queue-level reference model.
module tb_iaoq_sequencer;
   localparam int AW = 8;
   localparam int INC = 4;

   logic          clk = 1'b0;
   logic          reset, stall, br_valid, nullify_req;
   logic [AW-1:0] br_target;
   logic [AW-1:0] iaoq_front, iaoq_back;
   logic          in_dslot, fetch_nullify, br_pending;
`ifdef IAOQ_BRANCH_CNT_EN
   logic [15:0]   br_count;
`endif

   int checks = 0;
   int failures = 0;

   // reference model: queue contents plus "what is owed" on the next advance
   int  m_front, m_back, m_ptgt, m_cnt;
   bit  m_dslot, m_nul, m_pend, m_nulpend;

   always #5 clk = ~clk;

   iaoq_sequencer #(.AW(AW), .INC(INC), .RESET_FRONT(0), .RESET_BACK(4)) dut (
      .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
      .br_target(br_target), .nullify_req(nullify_req),
      .iaoq_front(iaoq_front), .iaoq_back(iaoq_back), .in_dslot(in_dslot),
      .fetch_nullify(fetch_nullify), .br_pending(br_pending)
`ifdef IAOQ_BRANCH_CNT_EN
      , .br_count(br_count)
`endif
   );

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model(input bit rst, input bit st, input bit bv, input int tgt, input bit nr);
      bit redir;
      if (rst) begin
         m_front = 0; m_back = 4; m_dslot = 0; m_nul = 0;
         m_pend = 0; m_nulpend = 0; m_ptgt = 0; m_cnt = 0;
      end else if (!st) begin
         redir   = bv || m_pend;
         m_front = m_back;
         m_back  = redir ? (bv ? tgt : m_ptgt) : (m_back + INC) % 256;
         m_dslot = redir;
         m_nul   = nr || m_nulpend;
         m_nulpend = 0;
         m_pend  = 0;
         if (redir && m_cnt < 65535) m_cnt++;
      end else begin
         if (bv) begin m_pend = 1; m_ptgt = tgt; end
         if (nr) m_nulpend = 1;
      end
   endtask

   task automatic check_all();
      chk("front", int'(iaoq_front), m_front);
      chk("back", int'(iaoq_back), m_back);
      chk("in_dslot", int'(in_dslot), int'(m_dslot));
      chk("fetch_nullify", int'(fetch_nullify), int'(m_nul));
      chk("br_pending", int'(br_pending), int'(m_pend));
`ifdef IAOQ_BRANCH_CNT_EN
      chk("br_count", int'(br_count), m_cnt);
`endif
   endtask

   // drive one cycle of inputs, advance the model, compare after the edge
   task automatic step(input bit rst, input bit st, input bit bv, input int tgt, input bit nr);
      reset = rst; stall = st; br_valid = bv; br_target = AW'(tgt); nullify_req = nr;
      model(rst, st, bv, tgt, nr);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      step(1, 0, 0, 0, 0);
      step(1, 1, 1, 8'h33, 1);
      chk("rst_front", int'(iaoq_front), 0);
      chk("rst_back", int'(iaoq_back), 4);
      // sequential advance then redirect from front=8/back=12
      step(0, 0, 0, 0, 0);
      chk("seq_front", int'(iaoq_front), 4);
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 8'h40, 0);
      chk("br_front", int'(iaoq_front), 12);
      chk("br_back", int'(iaoq_back), 8'h40);
      step(0, 0, 0, 0, 0);
      chk("dslot_exit_back", int'(iaoq_back), 8'h44);
      // branch during a 3-cycle stall with a nullify latched
      step(0, 1, 1, 8'h80, 1);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      chk("pend_flag", int'(br_pending), 1);
      step(0, 0, 0, 0, 0);
      chk("pend_release_back", int'(iaoq_back), 8'h80);
      chk("pend_release_nul", int'(fetch_nullify), 1);
      step(0, 0, 0, 0, 0);
      // wrap at the top of the address space
      step(0, 0, 1, 8'hF8, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("wrap_back", int'(iaoq_back), 0);
      chk("wrap_front", int'(iaoq_front), 8'hFC);
      // branch in delay slot, then reset while pending
      step(0, 0, 1, 8'h20, 0);
      step(0, 0, 1, 8'h60, 0);
      step(0, 1, 1, 8'h10, 1);
      step(0, 1, 1, 8'h14, 0);
      step(1, 1, 0, 0, 0);
      chk("rst_pend_front", int'(iaoq_front), 0);
      chk("rst_pend_flag", int'(br_pending), 0);
      step(0, 0, 0, 0, 0);
      chk("rst_pend_nul", int'(fetch_nullify), 0);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(99) == 0), ($urandom_range(2) == 0),
              ($urandom_range(4) == 0), int'($urandom_range(255)),
              ($urandom_range(5) == 0));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
